wb_arbiter_2m: RTL and testbench
================================

// Module: wb_arbiter_2m
// PURPOSE
//  Two-master, one-slave Wishbone classic arbiter that shares the unified memory slave between the
//  instruction-fetch port (M0) and the load/store port (M1). Sits between the core's bus masters and
//  the memory wrapper. Round-robin on contention, grant locked for a whole CYC, watchdog terminates
//  hung cycles with an error pulse.
// PARAMETERS
//  DW     32  data width
//  AW     30  word address width
//  SW      4  byte-select width (DW/8)
//  TMO   255  cycles a granted master may hold STB without ACK before timeout (1..2^TW-1)
//  TW      8  watchdog counter width
// PORTS
//  i_ck        in   1   clock, all state on rising edge
//  i_rst       in   1   reset, asynchronous, active-high
//  i_mN_cyc    in   1   master N bus cycle (N = 0,1; every mN port exists for both masters)
//  i_mN_stb    in   1   master N strobe
//  i_mN_we     in   1   master N write enable
//  i_mN_sel    in   SW  master N byte selects
//  i_mN_adr    in   AW  master N word address
//  i_mN_dat    in   DW  master N write data
//  o_mN_dat    out  DW  read data to master N
//  o_mN_ack    out  1   ack to master N
//  o_mN_err    out  1   one-cycle timeout error to master N
//  o_s_cyc     out  1   slave cycle
//  o_s_stb     out  1   slave strobe
//  o_s_we      out  1   slave write enable
//  o_s_sel     out  SW  slave byte selects
//  o_s_adr     out  AW  slave address
//  o_s_dat     out  DW  slave write data
//  i_s_dat     in   DW  slave read data
//  i_s_ack     in   1   slave ack
// BEHAVIOUR
//  - FSM states: IDLE, GNT0, GNT1. Reg last (last master granted), reg wdog[TW-1:0].
//  - Reset: state=IDLE, last=1 (so M0 wins first contention), wdog=0; all outputs 0.
//  - Request N = i_mN_cyc & i_mN_stb. Grant is registered: request seen at edge k, slave sees STB from
//    cycle after edge k (1 cycle arbitration latency from IDLE).
//  - IDLE: only reqN -> GNTN; both -> GNT of master != last; none -> stay. last updated on grant.
//  - GNTN: hold while i_mN_cyc=1 (STB may drop between beats, grant kept). On i_mN_cyc=0: if other
//    master requesting -> GNT(other) directly (no IDLE bubble), else IDLE.
//  - Slave outputs: mux of granted master; o_s_cyc/o_s_stb = granted master's cyc/stb, 0 in IDLE.
//  - Return path combinational: o_mN_ack = i_s_ack & GNTN; o_mN_dat = i_s_dat when GNTN else 0.
//    Non-granted master never sees ack or err.
//  - Watchdog: in GNTN, wdog increments each cycle with i_mN_stb=1 & i_s_ack=0; clears on ack, on
//    stb=0, and on any state change. When wdog==TMO: o_mN_err=1 for that cycle, o_s_cyc/o_s_stb
//    forced 0, next state as if cyc dropped (other master or IDLE), wdog=0. ack and err are exclusive;
//    ack in the same cycle as wdog==TMO wins (no err).
//  - Simultaneous: master drops cyc same cycle the other raises request -> handover next edge.
//    A master re-requesting after release waits if the other is pending (fairness).
//  - Reset asserted mid-transfer: outputs drop to 0 asynchronously; in-flight transfer abandoned,
//    masters restart after release; slave sees CYC fall.
// STRUCTURE
//  - Shared header wb_defs.vh: WB_DWIDTH/WB_AWIDTH/WB_SWIDTH and FSM state encodings
//    (ARB_IDLE=2'd0, ARB_GNT0=2'd1, ARB_GNT1=2'd2).
//  - One sub-module: wb_arb_wdog (counter + TMO compare, inputs run/clear, output expired).
//  - Top holds FSM, last register and muxes.
// TESTING
//  1 Reset: i_rst=1 mid-cycle -> all o_* = 0 immediately; after release first M0+M1 clash grants M0.
//  2 Single M1 write adr=0x10 dat=0xDEADBEEF sel=0xF -> o_s_stb one cycle after request,
//    o_m1_ack pulse, M0 ack stays 0; readback by M0 returns 0xDEADBEEF.
//  3 Both request continuously, 1-beat cycles -> grants alternate M0,M1,M0,M1 with no IDLE gap.
//  4 M0 holds cyc across 4 beats with stb gaps while M1 waits -> M1 granted only after M0 cyc=0.
//  5 Slave ack tied 0, TMO=4 -> o_m0_err high exactly on 5th stb cycle, then grant moves to
//    pending M1 or IDLE; no o_m0_ack.
//  6 Ack arrives in cycle wdog==TMO -> ack delivered, err stays 0.

Source files
------------

// File: rtl/wb_arbiter_2m_pkg.sv
// Shared widths and FSM encoding for the two-master Wishbone arbiter.
package wb_arbiter_2m_pkg;

  localparam int unsigned WbDWidth = 32;
  localparam int unsigned WbAWidth = 30;
  localparam int unsigned WbSWidth = WbDWidth / 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } arb_state_e;

  // Grant state belonging to master m.
  function automatic arb_state_e gnt_state(input logic m);
    return m ? StGnt1 : StGnt0;
  endfunction

endpackage

// File: rtl/wb_arbiter_2m_wdog.sv
// Hung-cycle watchdog: counts stalled strobe cycles and flags when the limit is reached.
module wb_arbiter_2m_wdog #(
  parameter int unsigned TMO = 255,
  parameter int unsigned TW  = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clear_i,
  output logic expired_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  // Clear has priority so a grant change always restarts the count from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == TW'(TMO));

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone classic arbiter: round-robin on contention, grant held for a
// whole CYC, watchdog aborts stalled cycles with a one-cycle error to the owning master.
module wb_arbiter_2m
  import wb_arbiter_2m_pkg::*;
#(
  parameter int unsigned DW  = WbDWidth,
  parameter int unsigned AW  = WbAWidth,
  parameter int unsigned SW  = WbSWidth,
  parameter int unsigned TMO = 255,
  parameter int unsigned TW  = 8
) (
  input  logic          i_ck,
  input  logic          i_rst,
  input  logic          i_m0_cyc,
  input  logic          i_m0_stb,
  input  logic          i_m0_we,
  input  logic [SW-1:0] i_m0_sel,
  input  logic [AW-1:0] i_m0_adr,
  input  logic [DW-1:0] i_m0_dat,
  output logic [DW-1:0] o_m0_dat,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  input  logic          i_m1_cyc,
  input  logic          i_m1_stb,
  input  logic          i_m1_we,
  input  logic [SW-1:0] i_m1_sel,
  input  logic [AW-1:0] i_m1_adr,
  input  logic [DW-1:0] i_m1_dat,
  output logic [DW-1:0] o_m1_dat,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  output logic          o_s_cyc,
  output logic          o_s_stb,
  output logic          o_s_we,
  output logic [SW-1:0] o_s_sel,
  output logic [AW-1:0] o_s_adr,
  output logic [DW-1:0] o_s_dat,
  input  logic [DW-1:0] i_s_dat,
  input  logic          i_s_ack
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       req0, req1, gnt0, gnt1;
  logic       wd_run, wd_clear, wd_expired, timeout;

  assign req0 = i_m0_cyc & i_m0_stb;
  assign req1 = i_m1_cyc & i_m1_stb;
  assign gnt0 = (state_q == StGnt0);
  assign gnt1 = (state_q == StGnt1);

  // An ack in the expiry cycle completes the beat normally, so it masks the timeout.
  assign timeout = wd_expired & ~i_s_ack & (gnt0 | gnt1);

  assign wd_run   = ((gnt0 & i_m0_stb) | (gnt1 & i_m1_stb)) & ~i_s_ack;
  assign wd_clear = ~wd_run | (state_d != state_q);

  wb_arbiter_2m_wdog #(
    .TMO(TMO),
    .TW (TW)
  ) u_wdog (
    .clk_i    (i_ck),
    .rst_i    (i_rst),
    .run_i    (wd_run),
    .clear_i  (wd_clear),
    .expired_o(wd_expired)
  );

  // Next grant: round-robin from idle, direct handover on release or timeout.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          state_d = gnt_state(~last_q);
          last_d  = ~last_q;
        end else if (req0) begin
          state_d = StGnt0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = StGnt1;
          last_d  = 1'b1;
        end
      end
      StGnt0: begin
        if (!i_m0_cyc || timeout) begin
          if (req1) begin
            state_d = StGnt1;
            last_d  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGnt1: begin
        if (!i_m1_cyc || timeout) begin
          if (req0) begin
            state_d = StGnt0;
            last_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Grant state and round-robin pointer; reset favours M0 on the first clash.
  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Forward path mux and gated return path; everything is zero while idle.
  always_comb begin
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_s_we   = 1'b0;
    o_s_sel  = '0;
    o_s_adr  = '0;
    o_s_dat  = '0;
    o_m0_dat = '0;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_dat = '0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    if (gnt0) begin
      o_s_cyc  = i_m0_cyc & ~timeout;
      o_s_stb  = i_m0_stb & ~timeout;
      o_s_we   = i_m0_we;
      o_s_sel  = i_m0_sel;
      o_s_adr  = i_m0_adr;
      o_s_dat  = i_m0_dat;
      o_m0_dat = i_s_dat;
      o_m0_ack = i_s_ack;
      o_m0_err = timeout;
    end else if (gnt1) begin
      o_s_cyc  = i_m1_cyc & ~timeout;
      o_s_stb  = i_m1_stb & ~timeout;
      o_s_we   = i_m1_we;
      o_s_sel  = i_m1_sel;
      o_s_adr  = i_m1_adr;
      o_s_dat  = i_m1_dat;
      o_m1_dat = i_s_dat;
      o_m1_ack = i_s_ack;
      o_m1_err = timeout;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m with a small memory slave model (programmable ack delay).
module tb_wb_arbiter_2m;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 30;
  localparam int unsigned SW  = 4;
  localparam int unsigned TMO = 4;
  localparam int unsigned TW  = 8;

  logic          i_ck = 1'b0;
  logic          i_rst;
  logic          i_m0_cyc, i_m0_stb, i_m0_we;
  logic [SW-1:0] i_m0_sel;
  logic [AW-1:0] i_m0_adr;
  logic [DW-1:0] i_m0_dat;
  logic [DW-1:0] o_m0_dat;
  logic          o_m0_ack, o_m0_err;
  logic          i_m1_cyc, i_m1_stb, i_m1_we;
  logic [SW-1:0] i_m1_sel;
  logic [AW-1:0] i_m1_adr;
  logic [DW-1:0] i_m1_dat;
  logic [DW-1:0] o_m1_dat;
  logic          o_m1_ack, o_m1_err;
  logic          o_s_cyc, o_s_stb, o_s_we;
  logic [SW-1:0] o_s_sel;
  logic [AW-1:0] o_s_adr;
  logic [DW-1:0] o_s_dat;
  logic [DW-1:0] i_s_dat;
  logic          i_s_ack;

  always #5 i_ck = ~i_ck;

  wb_arbiter_2m #(
    .DW (DW),
    .AW (AW),
    .SW (SW),
    .TMO(TMO),
    .TW (TW)
  ) u_dut (
    .i_ck    (i_ck),
    .i_rst   (i_rst),
    .i_m0_cyc(i_m0_cyc),
    .i_m0_stb(i_m0_stb),
    .i_m0_we (i_m0_we),
    .i_m0_sel(i_m0_sel),
    .i_m0_adr(i_m0_adr),
    .i_m0_dat(i_m0_dat),
    .o_m0_dat(o_m0_dat),
    .o_m0_ack(o_m0_ack),
    .o_m0_err(o_m0_err),
    .i_m1_cyc(i_m1_cyc),
    .i_m1_stb(i_m1_stb),
    .i_m1_we (i_m1_we),
    .i_m1_sel(i_m1_sel),
    .i_m1_adr(i_m1_adr),
    .i_m1_dat(i_m1_dat),
    .o_m1_dat(o_m1_dat),
    .o_m1_ack(o_m1_ack),
    .o_m1_err(o_m1_err),
    .o_s_cyc (o_s_cyc),
    .o_s_stb (o_s_stb),
    .o_s_we  (o_s_we),
    .o_s_sel (o_s_sel),
    .o_s_adr (o_s_adr),
    .o_s_dat (o_s_dat),
    .i_s_dat (i_s_dat),
    .i_s_ack (i_s_ack)
  );

  // Memory slave: acks after ack_delay stalled strobe cycles, never when ack_en is low.
  logic [31:0] mem [64];
  logic        ack_en;
  int unsigned ack_delay;
  int unsigned s_cnt;

  always @(posedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      i_s_ack <= 1'b0;
      i_s_dat <= '0;
      s_cnt   <= 0;
    end else if (o_s_stb && !i_s_ack) begin
      if (ack_en && s_cnt == ack_delay) begin
        i_s_ack <= 1'b1;
        s_cnt   <= 0;
        i_s_dat <= mem[o_s_adr[5:0]];
        if (o_s_we) begin
          for (int b = 0; b < 4; b++) begin
            if (o_s_sel[b]) mem[o_s_adr[5:0]][8*b +: 8] <= o_s_dat[8*b +: 8];
          end
        end
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end else begin
      i_s_ack <= 1'b0;
      s_cnt   <= 0;
    end
  end

  // Ack log for ordering and spacing checks.
  int unsigned cyc_n  = 0;
  int unsigned n_ack0 = 0;
  int unsigned n_ack1 = 0;
  int          ack_who[$];
  int unsigned ack_at[$];

  always @(posedge i_ck) cyc_n <= cyc_n + 1;

  always @(negedge i_ck) begin
    if (o_m0_ack) begin
      ack_who.push_back(0);
      ack_at.push_back(cyc_n);
      n_ack0 <= n_ack0 + 1;
    end
    if (o_m1_ack) begin
      ack_who.push_back(1);
      ack_at.push_back(cyc_n);
      n_ack1 <= n_ack1 + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{o_s_cyc, o_s_stb, o_s_we, o_s_sel, o_s_adr, o_s_dat, o_m0_dat, o_m1_dat,
             o_m0_ack, o_m1_ack, o_m0_err, o_m1_err};
  endfunction

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    if (m == 0) begin
      i_m0_cyc = cyc; i_m0_stb = stb; i_m0_we = we;
      i_m0_sel = 4'hF; i_m0_adr = adr; i_m0_dat = dat;
    end else begin
      i_m1_cyc = cyc; i_m1_stb = stb; i_m1_we = we;
      i_m1_sel = 4'hF; i_m1_adr = adr; i_m1_dat = dat;
    end
  endtask

  // One single-beat cycle, then one idle cycle; starts and ends just after a rising edge.
  task automatic do_xfer(input int m, input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input string tag,
                         output logic [DW-1:0] rdat);
    logic got;
    got  = 1'b0;
    rdat = '0;
    set_m(m, 1'b1, 1'b1, we, adr, dat);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge i_ck);
      if ((m == 0) ? o_m0_ack : o_m1_ack) begin
        got  = 1'b1;
        rdat = (m == 0) ? o_m0_dat : o_m1_dat;
      end
    end
    check_eq({tag, "_ack"}, 64'(got), 64'd1);
    @(posedge i_ck); #1;
    set_m(m, 1'b0, 1'b0, 1'b0, adr, dat);
    @(posedge i_ck); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [DW-1:0] rd0, rd1;
    logic          got;
    int            s;
    int unsigned   a0, a1;

    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    ack_en    = 1'b1;
    ack_delay = 0;
    i_rst     = 1'b0;
    #2 i_rst  = 1'b1;
    repeat (2) @(posedge i_ck);
    @(negedge i_ck);
    check_eq("rst_outs_zero", 64'(any_out()), 64'd0);
    i_rst = 1'b0;

    // 1: reset in the middle of a granted cycle, then first clash goes to M0.
    @(posedge i_ck); #1;
    set_m(1, 1'b1, 1'b1, 1'b1, 30'h5, 32'h1111_0005);
    @(posedge i_ck);
    @(negedge i_ck);
    check_eq("t1_granted_cyc", 64'(o_s_cyc), 64'd1);
    #1 i_rst = 1'b1;
    #1;
    check_eq("t1_async_rst_outs", 64'(any_out()), 64'd0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge i_ck); #1;
    check_eq("t1_rst_hold_outs", 64'(any_out()), 64'd0);
    @(negedge i_ck);
    i_rst = 1'b0;
    @(posedge i_ck); #1;
    s = ack_who.size();
    fork
      do_xfer(0, 1'b1, 30'h21, 32'hA0A0_0021, "t1_m0", rd0);
      do_xfer(1, 1'b1, 30'h22, 32'hB1B1_0022, "t1_m1", rd1);
      begin
        @(posedge i_ck);
        @(negedge i_ck);
        check_eq("t1_clash_adr_m0", 64'(o_s_adr), 64'h21);
      end
    join
    check_eq("t1_ack_count", 64'(ack_who.size() - s), 64'd2);
    if (ack_who.size() >= s + 2) begin
      check_eq("t1_first_m0", 64'(ack_who[s]), 64'd0);
      check_eq("t1_second_m1", 64'(ack_who[s+1]), 64'd1);
    end

    // 2: M1 write with one-cycle arbitration latency, then M0 reads it back.
    fork
      do_xfer(1, 1'b1, 30'h10, 32'hDEAD_BEEF, "t2_wr", rd1);
      begin
        @(negedge i_ck);
        check_eq("t2_latency_stb", 64'(o_s_stb), 64'd0);
        @(negedge i_ck);
        check_eq("t2_stb", 64'(o_s_stb), 64'd1);
        check_eq("t2_adr", 64'(o_s_adr), 64'h10);
        check_eq("t2_dat", 64'(o_s_dat), 64'hDEAD_BEEF);
        check_eq("t2_sel_we", 64'({o_s_sel, o_s_we}), 64'h1F);
        @(negedge i_ck);
        check_eq("t2_m1_ack", 64'(o_m1_ack), 64'd1);
        check_eq("t2_m0_no_ack", 64'(o_m0_ack), 64'd0);
      end
    join
    do_xfer(0, 1'b0, 30'h10, 32'h0, "t2_rd", rd0);
    check_eq("t2_readback", 64'(rd0), 64'hDEAD_BEEF);

    // 3: continuous contention; last grant was M0, so M1 leads and they alternate.
    s = ack_who.size();
    fork
      for (int i = 0; i < 3; i++) do_xfer(0, 1'b1, AW'(32 + i), 32'h3000 + i, "t3_m0", rd0);
      for (int i = 0; i < 3; i++) do_xfer(1, 1'b1, AW'(40 + i), 32'h4000 + i, "t3_m1", rd1);
    join
    check_eq("t3_ack_count", 64'(ack_who.size() - s), 64'd6);
    if (ack_who.size() >= s + 6) begin
      for (int i = 0; i < 6; i++) begin
        check_eq($sformatf("t3_order%0d", i), 64'(ack_who[s+i]), 64'((i % 2 == 0) ? 1 : 0));
      end
      for (int i = 0; i < 5; i++) begin
        check_eq($sformatf("t3_spacing%0d", i), 64'(ack_at[s+i+1] - ack_at[s+i]), 64'd3);
      end
    end

    // 4: M0 keeps CYC over four beats with strobe gaps while M1 waits.
    set_m(0, 1'b1, 1'b1, 1'b1, 30'h30, 32'h5000_0000);
    @(posedge i_ck); #1;
    set_m(1, 1'b1, 1'b1, 1'b1, 30'h38, 32'h6000_0000);
    a0 = n_ack0;
    a1 = n_ack1;
    for (int b = 0; b < 4; b++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge i_ck);
        got = o_m0_ack;
      end
      check_eq($sformatf("t4_beat%0d_ack", b), 64'(got), 64'd1);
      @(posedge i_ck); #1;
      i_m0_stb = 1'b0;
      i_m0_adr = i_m0_adr + 30'd1;
      @(negedge i_ck);
      check_eq($sformatf("t4_gap%0d_cyc_stb", b), 64'({o_s_cyc, o_s_stb}), 64'b10);
      @(posedge i_ck); #1;
      if (b < 3) i_m0_stb = 1'b1;
    end
    check_eq("t4_m0_beats", 64'(n_ack0 - a0), 64'd4);
    check_eq("t4_m1_waited", 64'(n_ack1 - a1), 64'd0);
    i_m0_cyc = 1'b0;
    i_m0_we  = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge i_ck);
      got = o_m1_ack;
    end
    check_eq("t4_m1_after_release", 64'(got), 64'd1);
    @(posedge i_ck); #1;
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge i_ck); #1;

    // 5: slave never acks; M0 errors on its fifth strobe cycle, grant passes to M1.
    ack_en = 1'b0;
    a0 = n_ack0;
    set_m(0, 1'b1, 1'b1, 1'b0, 30'h60, 32'h0);
    @(posedge i_ck); #1;
    set_m(1, 1'b1, 1'b1, 1'b1, 30'h70, 32'h7777_0070);
    for (int k = 1; k <= 5; k++) begin
      @(negedge i_ck);
      check_eq($sformatf("t5_err_c%0d", k), 64'(o_m0_err), 64'(k == 5));
      check_eq($sformatf("t5_stb_c%0d", k), 64'(o_s_stb), 64'(k != 5));
    end
    check_eq("t5_m1_no_err", 64'(o_m1_err), 64'd0);
    @(posedge i_ck); #1;
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    ack_en = 1'b1;
    @(negedge i_ck);
    check_eq("t5_handover_adr", 64'(o_s_adr), 64'h70);
    check_eq("t5_handover_stb_err", 64'({o_s_stb, o_m0_err}), 64'b10);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge i_ck);
      got = o_m1_ack;
    end
    check_eq("t5_m1_ack", 64'(got), 64'd1);
    check_eq("t5_no_m0_ack", 64'(n_ack0 - a0), 64'd0);
    @(posedge i_ck); #1;
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge i_ck); #1;

    // 6: ack lands in the very cycle the watchdog reaches its limit; ack wins.
    ack_delay = 3;
    set_m(0, 1'b1, 1'b1, 1'b1, 30'h80, 32'h8888_0080);
    @(posedge i_ck); #1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge i_ck);
      check_eq($sformatf("t6_err_c%0d", k), 64'(o_m0_err), 64'd0);
      check_eq($sformatf("t6_ack_c%0d", k), 64'(o_m0_ack), 64'(k == 5));
    end
    check_eq("t6_stb_kept", 64'(o_s_stb), 64'd1);
    @(posedge i_ck); #1;
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    ack_delay = 0;
    @(posedge i_ck); #1;
    do_xfer(1, 1'b0, 30'h80, 32'h0, "t6_rd", rd1);
    check_eq("t6_readback", 64'(rd1), 64'h8888_0080);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
